lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

HD44780-compatible character LCD write sequencer, fed by the LSU's memory-mapped LCD register path. It runs the power-up initialisation sequence, then accepts one command or data byte at a time over a valid/ready handshake. For each byte it generates correctly timed RS/EN/DATA pin waveforms and holds off until the display's execution time has elapsed. Write-only: RW is tied low and the busy flag is never read; all pacing is by cycle counters.

## Interface
Parameters (cycle counts at i_clk; every value must be ≥ 1):
- P_POWERUP, 750000, wait after reset before the first init write (15 ms at 50 MHz)
- P_SETUP, 2, cycles RS/DATA are stable before EN rises
- P_EN_HIGH, 12, EN high pulse width
- P_HOLD, 2, cycles RS/DATA are held after EN falls
- P_EXEC, 2000, post-write wait for normal commands and data (40 µs)
- P_CLEAR, 82000, post-write wait for clear/home commands (1.64 ms)

Ports (reset i_reset, synchronous, active-high; clock i_clk):
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_valid  in  1  byte request
- i_rs  in  1  0 = command, 1 = character data
- i_data  in  8  byte to write
- o_ready  out  1  request accepted on an edge where i_valid && o_ready
- o_init_done  out  1  init sequence finished; stays high until reset
- o_lcd_on  out  1  panel power/backlight enable
- o_lcd_en  out  1  LCD EN pin
- o_lcd_rs  out  1  LCD RS pin
- o_lcd_rw  out  1  LCD RW pin, constant 0
- o_lcd_data  out  8  LCD DB7..DB0

## Operation
- States: PWRUP, IDLE, SETUP, EN_HI, HOLD, WAIT.
- One down-counter, width $clog2 of the largest parameter. A phase of length P loads P-1 on entry and exits when the counter equals 0, so the phase lasts exactly P cycles.
- PWRUP runs for P_POWERUP cycles. The block then writes the init ROM in order, RS=0: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. Each init byte uses the same SETUP→EN_HI→HOLD→WAIT path as a user write.
- o_init_done rises on the cycle the last init WAIT ends. The block then enters IDLE.
- o_ready = 1 only in IDLE with o_init_done = 1. It is combinational from the state register.
- On accept, i_rs/i_data are latched into o_lcd_rs/o_lcd_data, and the state goes to SETUP.
- SETUP: EN=0 for P_SETUP cycles.
- EN_HI: EN=1 for P_EN_HIGH cycles.
- HOLD: EN=0 for P_HOLD cycles.
- WAIT: EN=0. Length is P_CLEAR when RS=0 and data ∈ {0x01, 0x02, 0x03} (clear/return home); otherwise P_EXEC.
- o_lcd_rs/o_lcd_data change only on accept or init-ROM advance. They hold their value through HOLD, WAIT and IDLE.
- i_valid while o_ready = 0 (PWRUP, init, busy) is ignored. There is no queue, and the upstream must hold the request until it is accepted.

## Timing
- Values while and immediately after reset: o_ready=0, o_init_done=0, o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0x00, o_lcd_on=0. State=PWRUP, ROM index=0.
- o_lcd_on goes to 1 on the first edge with i_reset low and stays 1.
- All outputs are registered except o_ready.
- The accepting edge is edge 0. EN is high during cycles P_SETUP+1 through P_SETUP+P_EN_HIGH.
- o_ready reasserts P_SETUP+P_EN_HIGH+P_HOLD+W cycles after edge 0, where W is the WAIT length. With defaults this is 2016 for data and 82016 for clear.
- First init EN rise occurs P_POWERUP+P_SETUP cycles after reset deasserts.
- Back-to-back: if i_valid is held high, the next accept happens on the first edge o_ready is high. There is no idle bubble.
- Reset mid-write (any state) aborts: EN is low at the next edge, init_done clears, and the power-up and init sequence repeat in full.
- A clear/home opcode with RS=1 is data and uses P_EXEC.

## Test plan
Bench parameters: P_POWERUP=20, P_SETUP=2, P_EN_HIGH=3, P_HOLD=1, P_EXEC=5, P_CLEAR=15.
- Reset release -> o_lcd_on=1 next edge; EN pulses exactly 6 times with data 38,38,38,0C,01,06, RS=0, each pulse 3 cycles wide. The first EN rise is 22 cycles after reset release. The gap after 0x01 is 15 wait cycles versus 5 after the other bytes. o_init_done=1 and o_ready=1 after the final wait.
- After init, i_valid with rs=1, data=0x41 -> RS=1 and DATA=0x41 stable 2 cycles before EN; EN high 3 cycles; DATA unchanged during HOLD. o_ready returns 11 cycles after accept.
- Command rs=0, data=0x01 -> o_ready returns 21 cycles after accept. The same byte with rs=1 returns in 11 cycles.
- i_valid held high during PWRUP, init and a busy write with changing data -> no extra EN pulses. The pin data only ever shows the values actually accepted.
- i_valid held high with 3 queued bytes 0x48, 0x49, 0x21 (data) -> accepts spaced exactly 11 cycles apart, 3 EN pulses, correct pin data at each.
- Reset asserted while EN=1 during a user write -> EN=0 next edge, o_ready=0, o_init_done=0. After release, the full init sequence repeats as in scenario 1.

Source files
------------

// File: rtl/lcd_ctrl.sv
// ----------------------------------------------------------------------------
// lcd_ctrl
//
// Write-only sequencer for an HD44780-compatible character LCD. After reset it
// waits for the panel to power up, then writes the fixed init sequence
// (8-bit bus, 2 lines, display on, clear, entry mode). After that it accepts
// one command or data byte at a time from the LSU register path and produces
// the RS/EN/DATA pin waveform for it. The busy flag is never read. Instead, a
// counter waits out the display's execution time before the next byte.
//
// Ports
//   i_clk        clock; every P_* parameter is a count of these cycles
//   i_reset      synchronous, active-high reset; aborts any write in flight
//   i_valid      byte request from upstream
//   i_rs         0 = command byte, 1 = character data
//   i_data       byte to write
//   o_ready      high only in IDLE after init (combinational from state)
//   o_init_done  init sequence complete; stays high until reset
//   o_lcd_on     panel power / backlight enable
//   o_lcd_en     LCD EN pin
//   o_lcd_rs     LCD RS pin
//   o_lcd_rw     LCD RW pin, tied low (write-only)
//   o_lcd_data   LCD DB7..DB0
//
// Handshake: a byte is transferred on a rising i_clk edge where
// i_valid && o_ready. o_ready does not depend on i_valid. A request seen while
// o_ready is low is ignored, and nothing is queued. Upstream keeps i_valid,
// i_rs and i_data steady until the transfer edge. If i_valid stays high, the
// next byte is taken on the first edge where o_ready is high again.
//
// The FSM state is held in the register 'state' (type state_t) so that
// checkers can bind to it.
// ----------------------------------------------------------------------------
module lcd_ctrl #(
  parameter int P_POWERUP = 750000,
  parameter int P_SETUP   = 2,
  parameter int P_EN_HIGH = 12,
  parameter int P_HOLD    = 2,
  parameter int P_EXEC    = 2000,
  parameter int P_CLEAR   = 82000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int P_MAX = max2(max2(max2(P_POWERUP, P_SETUP), max2(P_EN_HIGH, P_HOLD)),
                              max2(P_EXEC, P_CLEAR));
  // The counter only ever holds P-1, so $clog2 of the largest P is wide enough.
  // Keep at least one bit so the design still builds when every parameter is 1.
  localparam int CNT_W = ($clog2(P_MAX) < 1) ? 1 : $clog2(P_MAX);

  // Each phase of length P loads P-1 on entry and leaves when the count is 0.
  localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(P_POWERUP - 1);
  localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(P_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN_HIGH = CNT_W'(P_EN_HIGH - 1);
  localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(P_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC    = CNT_W'(P_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR   = CNT_W'(P_CLEAR - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [2:0] ROM_LAST = 3'd5;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_EN_HI = 3'd3,
    ST_HOLD  = 3'd4,
    ST_WAIT  = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       rom_idx;

  // Power-up init sequence. All of these are written with RS=0.
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h38;  // function set: 8-bit, 2 lines, 5x8
      3'd1:    b = 8'h38;
      3'd2:    b = 8'h38;
      3'd3:    b = 8'h0C;  // display on, cursor off
      3'd4:    b = 8'h01;  // clear display
      3'd5:    b = 8'h06;  // entry mode: increment, no shift
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long execution
  // time. The same byte values sent as character data (RS=1) do not.
  function automatic logic needs_long_wait(input logic rs, input logic [7:0] d);
    return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
  endfunction

  assign o_ready  = (state == ST_IDLE) && o_init_done;
  assign o_lcd_rw = 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_PWRUP;
      cnt         <= LD_POWERUP;
      rom_idx     <= 3'd0;
      o_init_done <= 1'b0;
      o_lcd_on    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_rs    <= 1'b0;
      o_lcd_data  <= 8'h00;
    end else begin
      o_lcd_on <= 1'b1;
      case (state)
        ST_PWRUP: begin
          if (cnt == CNT_ZERO) begin
            // Power-up delay is over. Present the first init byte.
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= init_byte(rom_idx);
            cnt        <= LD_SETUP;
            state      <= ST_SETUP;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_IDLE: begin
          if (i_valid && o_ready) begin
            o_lcd_rs   <= i_rs;
            o_lcd_data <= i_data;
            cnt        <= LD_SETUP;
            state      <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == CNT_ZERO) begin
            o_lcd_en <= 1'b1;
            cnt      <= LD_EN_HIGH;
            state    <= ST_EN_HI;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_EN_HI: begin
          if (cnt == CNT_ZERO) begin
            o_lcd_en <= 1'b0;
            cnt      <= LD_HOLD;
            state    <= ST_HOLD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_HOLD: begin
          if (cnt == CNT_ZERO) begin
            // The wait length is chosen from the byte still on the pins.
            cnt   <= needs_long_wait(o_lcd_rs, o_lcd_data) ? LD_CLEAR : LD_EXEC;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_WAIT: begin
          if (cnt == CNT_ZERO) begin
            if (o_init_done) begin
              state <= ST_IDLE;
            end else if (rom_idx == ROM_LAST) begin
              o_init_done <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              // Move on to the next init byte. It goes through the same path
              // as a user write.
              rom_idx    <= rom_idx + 3'd1;
              o_lcd_rs   <= 1'b0;
              o_lcd_data <= init_byte(rom_idx + 3'd1);
              cnt        <= LD_SETUP;
              state      <= ST_SETUP;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          o_lcd_en <= 1'b0;
          cnt      <= LD_POWERUP;
          rom_idx  <= 3'd0;
          state    <= ST_PWRUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lcd_ctrl
//
// Bench for lcd_ctrl, built with small timing parameters.
//
// Each byte the bench expects on the pins is pushed as {rs, data} onto exp_q:
//   - the six init bytes when reset is released;
//   - each user byte on the edge where it is accepted.
// A monitor pops one entry on every EN rising edge and compares it with the
// pins. The monitor also checks:
//   - setup stability before EN rises;
//   - the EN pulse width;
//   - that the pins stay unchanged while EN is high and during the hold cycle.
// The main sequence checks reset values, init timing, the o_ready return
// delay for a table of vectors, and the multi-cycle corner cases.
// ----------------------------------------------------------------------------
module tb_lcd_ctrl;

  localparam int P_POWERUP = 20;
  localparam int P_SETUP   = 2;
  localparam int P_EN_HIGH = 3;
  localparam int P_HOLD    = 1;
  localparam int P_EXEC    = 5;
  localparam int P_CLEAR   = 15;

  localparam int TOT_EXEC  = P_SETUP + P_EN_HIGH + P_HOLD + P_EXEC;   // 11
  localparam int TOT_CLEAR = P_SETUP + P_EN_HIGH + P_HOLD + P_CLEAR;  // 21
  localparam int BOUND      = 200;
  localparam int INIT_BOUND = 1000;

  logic       clk;
  logic       i_reset;
  logic       i_valid;
  logic       i_rs;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_init_done;
  logic       o_lcd_on;
  logic       o_lcd_en;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic [7:0] o_lcd_data;

  lcd_ctrl #(
    .P_POWERUP(P_POWERUP),
    .P_SETUP  (P_SETUP),
    .P_EN_HIGH(P_EN_HIGH),
    .P_HOLD   (P_HOLD),
    .P_EXEC   (P_EXEC),
    .P_CLEAR  (P_CLEAR)
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_rs       (i_rs),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .o_init_done(o_init_done),
    .o_lcd_on   (o_lcd_on),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_data (o_lcd_data)
  );

  // -------------------------------------------------------------- clock/reset
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------- scoreboard
  logic [8:0] exp_q[$];
  int         rise_q[$];
  int         fall_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] init_rom[6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Pin monitor, sampled on the falling edge.
  logic       en_prev   = 1'b0;
  logic [8:0] pins_prev = '0;
  logic [8:0] cap       = '0;
  logic [8:0] exp_pins;
  int         stable    = 0;
  int         width     = 0;

  initial begin : monitor
    logic [8:0] pins;
    forever begin
      @(negedge clk);
      pins = {o_lcd_rs, o_lcd_data};
      if (i_reset) begin
        en_prev   = 1'b0;
        pins_prev = pins;
        stable    = 0;
        width     = 0;
      end else begin
        if (o_lcd_en && !en_prev) begin
          rise_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL en_pulse: unexpected EN pulse, pins 0x%0h, no byte pending", pins);
          end else begin
            exp_pins = exp_q.pop_front();
            check("en_pins", pins, exp_pins);
          end
          check("setup_stable", (pins == pins_prev) && (stable >= P_SETUP), 1);
          check("rw_low", o_lcd_rw, 0);
          cap   = pins;
          width = 1;
        end else if (o_lcd_en) begin
          width++;
          check("en_hi_pins", pins, cap);
        end else if (en_prev) begin
          fall_q.push_back(cyc);
          check("en_width", width, P_EN_HIGH);
          check("hold_pins", pins, cap);
        end
        stable    = (pins == pins_prev) ? stable + 1 : 1;
        pins_prev = pins;
        en_prev   = o_lcd_en;
      end
    end
  end

  // -------------------------------------------------------------- driver tasks
  int last_rdy = 0;

  // Called at a falling edge. Holds the request until it is accepted, then
  // returns at the falling edge after the accepting edge. i_valid stays high.
  task automatic send(input logic rs, input logic [7:0] d, output int acc);
    int n;
    n       = 0;
    i_valid = 1'b1;
    i_rs    = rs;
    i_data  = d;
    while (!o_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      fail_now("send_ready");
      i_valid = 1'b0;
      acc     = cyc;
      return;
    end
    last_rdy = cyc;
    exp_q.push_back({rs, d});
    @(negedge clk);
    acc = cyc;
    check("accepted_busy", o_ready, 0);
    check("latched_pins", {o_lcd_rs, o_lcd_data}, {rs, d});
  endtask

  task automatic wait_ready(output int at);
    int n;
    n = 0;
    while (!o_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) fail_now("wait_ready");
    at = cyc;
  endtask

  // Releases reset and checks the whole init sequence. When noisy is set,
  // junk requests are driven the whole time; none of them may reach the pins.
  task automatic release_and_init(input bit noisy);
    int n;
    int rel;
    int done_cyc;
    int w;
    rise_q.delete();
    fall_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, init_rom[i]});
    i_reset = 1'b0;
    rel     = cyc;
    @(negedge clk);
    check("lcd_on_after_release", o_lcd_on, 1);
    check("init_done_early", o_init_done, 0);
    n = 0;
    while (!o_init_done && n < INIT_BOUND) begin
      i_valid = noisy;
      i_rs    = 1'($urandom_range(0, 1));
      i_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      n++;
    end
    i_valid = 1'b0;
    if (!o_init_done) begin
      fail_now("init_done_wait");
      return;
    end
    done_cyc = cyc;
    check("init_ready", o_ready, 1);
    check("init_pulse_count", rise_q.size(), 6);
    check("init_queue_drained", exp_q.size(), 0);
    if (rise_q.size() == 6 && fall_q.size() == 6) begin
      check("first_en_rise", rise_q[0] - rel, P_POWERUP + P_SETUP);
      for (int i = 0; i < 5; i++) begin
        // EN-low cycles between pulses: hold + wait + setup. The byte 0x01
        // (index 4) gets the clear wait.
        w = (i == 4) ? P_CLEAR : P_EXEC;
        check("init_gap", rise_q[i + 1] - fall_q[i], P_HOLD + w + P_SETUP);
      end
      check("init_done_time", done_cyc - rise_q[5], P_EN_HIGH + P_HOLD + P_EXEC);
    end
  endtask

  // -------------------------------------------------------------- test
  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         ready_cycles;
  } vec_t;

  vec_t vecs[9];

  initial begin : main
    int acc;
    int acc2;
    int r;
    int n;

    vecs[0] = '{1'b1, 8'h41, TOT_EXEC};
    vecs[1] = '{1'b0, 8'h01, TOT_CLEAR};
    vecs[2] = '{1'b1, 8'h01, TOT_EXEC};
    vecs[3] = '{1'b0, 8'h02, TOT_CLEAR};
    vecs[4] = '{1'b0, 8'h03, TOT_CLEAR};
    vecs[5] = '{1'b1, 8'h03, TOT_EXEC};
    vecs[6] = '{1'b0, 8'h04, TOT_EXEC};
    vecs[7] = '{1'b0, 8'h80, TOT_EXEC};
    vecs[8] = '{1'b1, 8'hFF, TOT_EXEC};

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_rs    = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", o_ready, 0);
    check("rst_init_done", o_init_done, 0);
    check("rst_lcd_on", o_lcd_on, 0);
    check("rst_en", o_lcd_en, 0);
    check("rst_rs", o_lcd_rs, 0);
    check("rst_rw", o_lcd_rw, 0);
    check("rst_data", o_lcd_data, 8'h00);

    // Power-up and init, with junk requests the whole time.
    release_and_init(1'b1);

    // Table of single writes: o_ready return delay per byte class.
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].rs, vecs[i].data, acc);
      i_valid = 1'b0;
      wait_ready(r);
      check("ready_return", r - acc, vecs[i].ready_cycles);
    end

    // Busy write with the request held high and the data changing every cycle.
    send(1'b1, 8'h5A, acc);
    n = 0;
    while (!o_ready && n < BOUND) begin
      i_valid = 1'b1;
      i_rs    = 1'($urandom_range(0, 1));
      i_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      n++;
    end
    i_valid = 1'b0;
    if (!o_ready) fail_now("busy_noise_ready");
    check("busy_noise_return", cyc - acc, TOT_EXEC);

    // Three bytes with i_valid held high. Each next byte must be taken on the
    // first edge where o_ready is high.
    send(1'b1, 8'h48, acc);
    send(1'b1, 8'h49, acc2);
    check("b2b_ready_1", last_rdy - acc, TOT_EXEC);
    send(1'b1, 8'h21, acc);
    check("b2b_ready_2", last_rdy - acc2, TOT_EXEC);
    i_valid = 1'b0;
    wait_ready(r);
    check("b2b_ready_3", r - acc, TOT_EXEC);
    check("b2b_queue_drained", exp_q.size(), 0);

    // Reset while EN is high during a user write.
    send(1'b1, 8'h55, acc);
    i_valid = 1'b0;
    n = 0;
    while (!o_lcd_en && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!o_lcd_en) fail_now("wait_en_high");
    i_reset = 1'b1;
    @(negedge clk);
    check("midrst_en", o_lcd_en, 0);
    check("midrst_ready", o_ready, 0);
    check("midrst_init_done", o_init_done, 0);
    exp_q.delete();
    @(negedge clk);
    release_and_init(1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
